// File: rtl/hi14a_subcarrier_demod.sv
// -----------------------------------------------------------------------------
// hi14a_subcarrier_demod
//
// Tag->reader subcarrier demodulator for the HF ISO14443-A receive chain.
// ADC samples pass through a 5-tap derivative (edge) filter. Each detection
// window of 2^WIN_LOG2 ticks tracks the largest falling edge and the deepest
// rising edge. At the programmable window phase it decides one bit:
// subcarrier present when both edges exceed the threshold. Bits are packed
// MSB-first into WORD_W-bit words and offered on a valid/ready port.
//
// Ports
//   adc_clk      in   sample clock, all logic on posedge
//   reset        in   asynchronous, active-high, clears all state
//   enable       in   1 = demodulate, 0 = hold window/word assembly idle
//   adc_d        in   ADC sample (unsigned)
//   reset_phase  in   window phase at which the bit decision happens
//   edge_thresh  in   unsigned edge threshold
//   clr_overflow in   clears the sticky overflow flag
//   curbit       out  last window decision
//   bit_strobe   out  one-cycle pulse when curbit updates
//   word_data    out  assembled word, MSB = first bit received
//   word_valid   out  word_data holds an unaccepted word
//   word_ready   in   consumer ready
//   overflow     out  sticky, a completed word was dropped
//   win_phase    out  current window counter
//
// Handshake: a word transfers on a cycle where word_valid & word_ready are
// both high. While word_valid is high and word_ready low, word_data is held
// stable. A word completing while the port is stalled is dropped and raises
// overflow; the held word is never overwritten.
// -----------------------------------------------------------------------------
module hi14a_subcarrier_demod #(
    parameter int ADC_W    = 8,
    parameter int WIN_LOG2 = 4,
    parameter int WORD_W   = 8
) (
    input  logic                adc_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [ADC_W-1:0]    adc_d,
    input  logic [WIN_LOG2-1:0] reset_phase,
    input  logic [ADC_W+1:0]    edge_thresh,
    input  logic                clr_overflow,
    output logic                curbit,
    output logic                bit_strobe,
    output logic [WORD_W-1:0]   word_data,
    output logic                word_valid,
    input  logic                word_ready,
    output logic                overflow,
    output logic [WIN_LOG2-1:0] win_phase
);

    localparam int FW = ADC_W + 3;
    localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic signed [FW-1:0] ZERO = '0;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

    logic [ADC_W-1:0]       p1_q, p2_q, p3_q, p4_q;
    logic signed [FW-1:0]   fq_q, fq_d;
    logic signed [FW-1:0]   fall_max_q, fall_max_d;
    logic signed [FW-1:0]   rise_min_q, rise_min_d;
    logic [WIN_LOG2-1:0]    win_q, win_d;
    logic [CW-1:0]          bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0]      shreg_q, shreg_d;
    logic                   curbit_q, curbit_d;
    logic                   strobe_q, strobe_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;

    logic [FW-1:0]          x0, x1, x3, x4;
    logic signed [FW-1:0]   thr, neg_thr;
    logic                   decide, new_bit, complete;

    // Operands zero-extended to FW bits; |f| <= 3*(2^ADC_W-1) always fits.
    always_comb begin
        x0   = {3'b000, adc_d};
        x1   = {3'b000, p1_q};
        x3   = {3'b000, p3_q};
        x4   = {3'b000, p4_q};
        fq_d = signed'(((x4 << 1) + x3) - ((x0 << 1) + x1));
    end

    assign thr     = signed'({1'b0, edge_thresh});
    assign neg_thr = -thr;
    assign decide  = enable && (win_q == reset_phase);
    assign new_bit = (fall_max_q > thr) && (rise_min_q < neg_thr);

    // Window tracking, bit decision and word assembly.
    always_comb begin
        win_d      = win_q + 1'b1;
        fall_max_d = fall_max_q;
        rise_min_d = rise_min_q;
        curbit_d   = curbit_q;
        strobe_d   = 1'b0;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        complete   = 1'b0;
        if (!enable) begin
            win_d      = '0;
            fall_max_d = '0;
            rise_min_d = '0;
            shreg_d    = '0;
            bitcnt_d   = '0;
        end else if (decide) begin
            // The filter sample of the decision cycle is discarded.
            curbit_d   = new_bit;
            strobe_d   = 1'b1;
            fall_max_d = '0;
            rise_min_d = '0;
            shreg_d    = {shreg_q[WORD_W-2:0], new_bit};
            if (bitcnt_q == LAST_BIT) begin
                bitcnt_d = '0;
                complete = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end else begin
            if ((fq_q > ZERO) && (fq_q > fall_max_q)) begin
                fall_max_d = fq_q;
            end else if ((fq_q <= ZERO) && (fq_q < rise_min_q)) begin
                rise_min_d = fq_q;
            end
        end
    end

    // Output port handoff; keeps running while disabled.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (clr_overflow) begin
            ovf_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || word_ready) begin
                word_d  = shreg_d;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;   // set wins over a simultaneous clear
            end
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            p1_q       <= '0;
            p2_q       <= '0;
            p3_q       <= '0;
            p4_q       <= '0;
            fq_q       <= '0;
            fall_max_q <= '0;
            rise_min_q <= '0;
            win_q      <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            curbit_q   <= 1'b0;
            strobe_q   <= 1'b0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            p1_q       <= adc_d;
            p2_q       <= p1_q;
            p3_q       <= p2_q;
            p4_q       <= p3_q;
            fq_q       <= fq_d;
            fall_max_q <= fall_max_d;
            rise_min_q <= rise_min_d;
            win_q      <= win_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            curbit_q   <= curbit_d;
            strobe_q   <= strobe_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign curbit     = curbit_q;
    assign bit_strobe = strobe_q;
    assign word_data  = word_q;
    assign word_valid = valid_q;
    assign overflow   = ovf_q;
    assign win_phase  = win_q;

endmodule
